// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: ALU select codes and the FSM state encoding.
package alu_pkg;

   localparam logic [1:0] SEL_ADD = 2'b00;
   localparam logic [1:0] SEL_SUB = 2'b01;
   localparam logic [1:0] SEL_MUL = 2'b10;
   localparam logic [1:0] SEL_DIV = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      EXEC = 2'b01,
      RESP = 2'b10
   } state_t;

endpackage

// File: rtl/alu_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping modulo NREQ.
module rr_arbiter #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   output logic [NREQ-1:0] grant,
   output logic [IDW-1:0]  idx,
   output logic            any
);

   logic [IDW-1:0] cand;

   always_comb begin
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      cand  = '0;
      for (int k = 0; k < NREQ; k++) begin
         cand = IDW'((int'(ptr) + k) % NREQ);
         if (!any && req[cand]) begin
            any = 1'b1;
            idx = cand;
         end
      end
      if (any) grant[idx] = 1'b1;
   end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one external combinational 8-bit ALU among NREQ requesters,
// one operation in flight: grant (IDLE) -> ALU evaluate (EXEC) -> hold response (RESP).
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [NREQ*8-1:0] req_a,
   input  logic [NREQ*8-1:0] req_b,
   input  logic [NREQ*2-1:0] req_sel,
   output logic [7:0]        alu_a,
   output logic [7:0]        alu_b,
   output logic [1:0]        alu_sel,
   input  logic [7:0]        alu_out,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [IDW-1:0]    rsp_id,
   output logic [7:0]        rsp_data,
   output logic              rsp_err,
   output logic              busy
);

   logic [NREQ-1:0][7:0] a_arr, b_arr;
   logic [NREQ-1:0][1:0] sel_arr;

   assign a_arr   = req_a;
   assign b_arr   = req_b;
   assign sel_arr = req_sel;

   state_t         state_q, state_d;
   logic [IDW-1:0] rr_ptr, op_id, gnt_idx;
   logic [NREQ-1:0] gnt;
   logic           gnt_any;
   logic [7:0]     op_a, op_b;
   logic [1:0]     op_sel;
   logic           div_zero;

   rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr (
      .req   (req_valid),
      .ptr   (rr_ptr),
      .grant (gnt),
      .idx   (gnt_idx),
      .any   (gnt_any)
   );

   assign alu_a    = op_a;
   assign alu_b    = op_b;
   assign alu_sel  = op_sel;
   assign busy     = (state_q != IDLE);
   assign div_zero = (op_sel == SEL_DIV) && (op_b == 8'd0);

   always_comb begin
      state_d   = state_q;
      req_ready = '0;
      unique case (state_q)
         IDLE: begin
            // Gated by rst_n so no requester sees an accept while reset is held.
            if (rst_n) req_ready = gnt;
            if (gnt_any) state_d = EXEC;
         end
         EXEC:    state_d = RESP;
         RESP:    if (rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr    <= '0;
         op_id     <= '0;
         op_a      <= '0;
         op_b      <= '0;
         op_sel    <= '0;
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_data  <= '0;
         rsp_err   <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: if (gnt_any) begin
               op_id  <= gnt_idx;
               op_a   <= a_arr[gnt_idx];
               op_b   <= b_arr[gnt_idx];
               op_sel <= sel_arr[gnt_idx];
            end
            EXEC: begin
               rsp_valid <= 1'b1;
               rsp_id    <= op_id;
               rsp_err   <= div_zero;
               rsp_data  <= div_zero ? 8'hFF : alu_out;
            end
            RESP: if (rsp_ready) begin
               rsp_valid <= 1'b0;
               rr_ptr    <= (op_id == IDW'(NREQ - 1)) ? '0 : op_id + 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule
